// File: rtl/ram_write_arbiter_if.sv
// Write-requester port bundle for ram_write_arbiter.
// Handshake: a beat transfers on a rising clk edge where valid && ready are
// both high. The master holds addr/data/last stable while valid is high and
// ready is low. last marks the final beat of a burst.
interface ram_write_arbiter_if #(
    parameter int AW = 6,
    parameter int DW = 8
);
    logic          valid;
    logic          ready;
    logic          last;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;

    modport master (output valid, addr, data, last, input ready);
    modport slave  (input valid, addr, data, last, output ready);
endinterface

// File: rtl/ram_write_arbiter.sv
// ram_write_arbiter: shares one image-RAM write port between the loader (s0)
// and the skeletonization engine (s1). Round-robin at burst boundaries, one
// registered write per cycle, out-of-range beats dropped with a sticky error,
// and a stalled owner loses its grant after TIMEOUT idle-valid cycles.
// Optional feature macro: WRARB_STATS_EN adds per-requester write counters
// wr_cnt0/wr_cnt1 (16-bit, saturating).
module ram_write_arbiter #(
    parameter int N          = 8,
    parameter int bitSize    = 6,
    parameter int pixelWidth = 8,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    ram_write_arbiter_if.slave    s0,
    ram_write_arbiter_if.slave    s1,
    output logic                  ram_we,
    output logic [bitSize-1:0]    ram_addr,
    output logic [pixelWidth-1:0] ram_data,
    output logic                  owner,
    output logic                  busy,
    output logic                  addr_err,
    output logic [1:0]            dbg_state
`ifdef WRARB_STATS_EN
    ,
    output logic [15:0]           wr_cnt0,
    output logic [15:0]           wr_cnt1
`endif
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    localparam int unsigned LIMIT = N * N;
    localparam logic [7:0]  TMO   = 8'(TIMEOUT);

    state_t state, state_nxt;
    logic   prio, prio_nxt;
    logic   owner_nxt;
    logic [7:0] tcnt, tcnt_nxt;

    logic                  acc;
    logic                  acc_last;
    logic                  cur_src;
    logic                  other_valid;
    logic                  acc_in_range;
    logic                  tmo_hit;
    logic [bitSize-1:0]    acc_addr;
    logic [pixelWidth-1:0] acc_data;

    // Readiness depends only on registered state, never on the inputs.
    assign s0.ready  = (state == GRANT0);
    assign s1.ready  = (state == GRANT1);
    assign busy      = (state != IDLE);
    assign dbg_state = state;

    // Select the owner's beat and the other requester's valid.
    always_comb begin
        acc         = 1'b0;
        acc_last    = 1'b0;
        cur_src     = 1'b0;
        other_valid = 1'b0;
        acc_addr    = '0;
        acc_data    = '0;
        case (state)
            GRANT0: begin
                acc         = s0.valid;
                acc_last    = s0.last;
                acc_addr    = s0.addr;
                acc_data    = s0.data;
                other_valid = s1.valid;
            end
            GRANT1: begin
                cur_src     = 1'b1;
                acc         = s1.valid;
                acc_last    = s1.last;
                acc_addr    = s1.addr;
                acc_data    = s1.data;
                other_valid = s0.valid;
            end
            default: ;
        endcase
    end

    assign acc_in_range = (32'(acc_addr) < LIMIT);
    assign tmo_hit      = (state != IDLE) && (tcnt == TMO);

    // Next-state, round-robin pointer, owner and stall counter.
    always_comb begin
        state_nxt = state;
        prio_nxt  = prio;
        owner_nxt = owner;
        tcnt_nxt  = tcnt;
        case (state)
            IDLE: begin
                tcnt_nxt = '0;
                if (s0.valid && (!s1.valid || !prio)) begin
                    state_nxt = GRANT0;
                    prio_nxt  = 1'b1;
                    owner_nxt = 1'b0;
                end else if (s1.valid) begin
                    state_nxt = GRANT1;
                    prio_nxt  = 1'b0;
                    owner_nxt = 1'b1;
                end
            end
            GRANT0, GRANT1: begin
                if (acc) tcnt_nxt = '0;
                else     tcnt_nxt = tcnt + 8'd1;
                // A timeout releases the grant exactly like an accepted last beat.
                if ((acc && acc_last) || tmo_hit) begin
                    tcnt_nxt = '0;
                    if (other_valid) begin
                        state_nxt = cur_src ? GRANT0 : GRANT1;
                        prio_nxt  = cur_src;
                        owner_nxt = ~cur_src;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Control registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            prio  <= 1'b0;
            owner <= 1'b0;
            tcnt  <= '0;
        end else begin
            state <= state_nxt;
            prio  <= prio_nxt;
            owner <= owner_nxt;
            tcnt  <= tcnt_nxt;
        end
    end

    // Registered RAM write port; address/data hold while no write is issued.
    always_ff @(posedge clk) begin
        if (rst) begin
            ram_we   <= 1'b0;
            ram_addr <= '0;
            ram_data <= '0;
            addr_err <= 1'b0;
        end else begin
            ram_we <= acc && acc_in_range;
            if (acc && acc_in_range) begin
                ram_addr <= acc_addr;
                ram_data <= acc_data;
            end
            if (acc && !acc_in_range) addr_err <= 1'b1;
        end
    end

`ifdef WRARB_STATS_EN
    // Saturating count of committed writes per requester.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt0 <= '0;
            wr_cnt1 <= '0;
        end else if (acc && acc_in_range) begin
            if (!cur_src && wr_cnt0 != 16'hFFFF) wr_cnt0 <= wr_cnt0 + 16'd1;
            if (cur_src && wr_cnt1 != 16'hFFFF)  wr_cnt1 <= wr_cnt1 + 16'd1;
        end
    end
`endif

endmodule
